cache_sdram_arbiter: RTL and testbench

Shares one SDRAM controller port between two cache clients: the instruction and data two-way caches, or a cache and a write path. Each client sees a private SDRAM port with the same req/rw/addr/fill semantics it would see attached directly. The arbiter grants one client at a time, forwards its request, steers the 4-word read burst or write acknowledge back to the owner, then re-arbitrates. It sits between the cache instances and the SDRAM controller.

---
 rtl/cache_sdram_arbiter.sv | 148 ++++++++++++++
 tb/tb_cache_sdram_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_sdram_arbiter.sv
// Arbitrates one SDRAM controller port between two cache clients.
// Define CACHE_ARB_FIXED_PRI_EN to give client 0 fixed priority on ties; default is round-robin.
module cache_sdram_arbiter #(
  parameter int BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        c0_req,
  input  logic        c1_req,
  input  logic        c0_rw,
  input  logic        c1_rw,
  input  logic [31:0] c0_addr,
  input  logic [31:0] c1_addr,
  input  logic [15:0] c0_wdata,
  input  logic [15:0] c1_wdata,
  output logic        c0_fill,
  output logic        c1_fill,
  output logic        c0_wr_ack,
  output logic        c1_wr_ack,
  output logic [15:0] rdata,
  output logic        mem_req,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_fill,
  input  logic        mem_wr_ack,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  // Handshake: a client holds req until its fill burst or wr_ack completes, and the
  // arbiter will not re-grant it until it has seen that req drop in RELEASE.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE   = 3'd1,
    RDBURST = 3'd2,
    WRWAIT  = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST_LEN - 1);

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          grant, grant_nx;
  logic          mem_req_nx, mem_rw_nx;
  logic [31:0]   mem_addr_nx;
  logic [15:0]   mem_wdata_nx;
  logic          winner;
  logic          granted_req;

  assign granted_req = grant ? c1_req : c0_req;

`ifdef CACHE_ARB_FIXED_PRI_EN
  assign winner = ~c0_req;
`else
  logic last_grant;

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant <= 1'b0;
    end else if (state == RELEASE && !granted_req) begin
      last_grant <= grant;
    end
  end

  assign winner = (c0_req & c1_req) ? ~last_grant : c1_req;
`endif

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    grant_nx     = grant;
    mem_req_nx   = mem_req;
    mem_rw_nx    = mem_rw;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    case (state)
      IDLE: begin
        if (c0_req | c1_req) begin
          grant_nx     = winner;
          mem_rw_nx    = winner ? c1_rw    : c0_rw;
          mem_addr_nx  = winner ? c1_addr  : c0_addr;
          mem_wdata_nx = winner ? c1_wdata : c0_wdata;
          cnt_nx       = '0;
          state_nx     = ISSUE;
        end
      end
      ISSUE: begin
        mem_req_nx = 1'b1;
        state_nx   = mem_rw ? RDBURST : WRWAIT;
      end
      RDBURST: begin
        // cnt==0 means the first word has not arrived yet
        if (cnt == '0) begin
          if (mem_fill) begin
            mem_req_nx = 1'b0;
            cnt_nx     = CW'(1);
          end
        end else begin
          cnt_nx = cnt + CW'(1);
          if (cnt == LAST_CNT) state_nx = RELEASE;
        end
      end
      WRWAIT: begin
        if (mem_wr_ack) begin
          mem_req_nx = 1'b0;
          state_nx   = RELEASE;
        end
      end
      RELEASE: begin
        if (!granted_req) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      grant     <= 1'b0;
      mem_req   <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      grant     <= grant_nx;
      mem_req   <= mem_req_nx;
      mem_rw    <= mem_rw_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
    end
  end

  assign c0_fill   = mem_fill   & ~grant & (state == RDBURST);
  assign c1_fill   = mem_fill   &  grant & (state == RDBURST);
  assign c0_wr_ack = mem_wr_ack & ~grant & (state == WRWAIT);
  assign c1_wr_ack = mem_wr_ack &  grant & (state == WRWAIT);
  assign rdata     = mem_rdata;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_cache_sdram_arbiter.sv
// Directed bench for cache_sdram_arbiter: read, write, tie arbitration, held request,
// reset mid-burst and spurious controller events.
module tb_cache_sdram_arbiter;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_RDBURST = 3'd2;
  localparam logic [2:0] S_WRWAIT  = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        c0_req, c1_req, c0_rw, c1_rw;
  logic [31:0] c0_addr, c1_addr;
  logic [15:0] c0_wdata, c1_wdata;
  logic        c0_fill, c1_fill, c0_wr_ack, c1_wr_ack;
  logic [15:0] rdata;
  logic        mem_req, mem_rw;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_fill, mem_wr_ack, busy;
  logic [2:0]  state_dbg;

  int tests = 0;
  int fails = 0;

  cache_sdram_arbiter dut (
    .clk(clk), .reset(reset),
    .c0_req(c0_req), .c1_req(c1_req), .c0_rw(c0_rw), .c1_rw(c1_rw),
    .c0_addr(c0_addr), .c1_addr(c1_addr), .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
    .c0_fill(c0_fill), .c1_fill(c1_fill), .c0_wr_ack(c0_wr_ack), .c1_wr_ack(c1_wr_ack),
    .rdata(rdata), .mem_req(mem_req), .mem_rw(mem_rw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_fill(mem_fill),
    .mem_wr_ack(mem_wr_ack), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    c0_req = 1'b0; c1_req = 1'b0;
    mem_fill = 1'b0; mem_wr_ack = 1'b0; mem_rdata = 16'h0;
    step(); step();
    reset = 1'b1;
  endtask

  // Waits for mem_req, then plays a 4-word burst and checks routing to owner.
  task automatic serve_read(input int owner, input logic [15:0] base);
    int n = 0;
    while (mem_req !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    chk("rd_req_seen", {31'b0, mem_req}, 32'd1);
    mem_fill = 1'b1; mem_rdata = base; #1;
    chk("fill_w1_c0", {31'b0, c0_fill}, (owner == 0) ? 32'd1 : 32'd0);
    chk("fill_w1_c1", {31'b0, c1_fill}, (owner == 1) ? 32'd1 : 32'd0);
    chk("rdata_w1", {16'b0, rdata}, {16'b0, base});
    step();
    mem_fill = 1'b0;
    for (int k = 1; k < 4; k++) begin
      mem_rdata = base + 16'(k); #1;
      chk("fill_wn_c0", {31'b0, c0_fill}, 32'd0);
      chk("fill_wn_c1", {31'b0, c1_fill}, 32'd0);
      chk("rdata_wn", {16'b0, rdata}, {16'b0, base + 16'(k)});
      chk("req_low_burst", {31'b0, mem_req}, 32'd0);
      chk("state_burst", {29'b0, state_dbg}, {29'b0, S_RDBURST});
      step();
    end
    mem_rdata = 16'h0; #1;
    chk("state_release", {29'b0, state_dbg}, {29'b0, S_RELEASE});
  endtask

  logic [31:0] tie_exp [3];
  int own;

  initial begin
`ifdef CACHE_ARB_FIXED_PRI_EN
    tie_exp = '{32'd0, 32'd0, 32'd0};
`else
    tie_exp = '{32'd1, 32'd0, 32'd1};
`endif
    c0_rw = 1'b0; c1_rw = 1'b0;
    c0_addr = 32'h0; c1_addr = 32'h0; c0_wdata = 16'h0; c1_wdata = 16'h0;
    step();
    do_reset();

    // reset state
    chk("rst_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", {16'b0, mem_wdata}, 32'h0);
    chk("rst_rw", {31'b0, mem_rw}, 32'd0);

    // single read by c0
    c0_req = 1'b1; c0_rw = 1'b1; c0_addr = 32'h0000_1238; #1;
    chk("rd_req_cycle0", {31'b0, mem_req}, 32'd0);
    step();
    chk("rd_issue", {29'b0, state_dbg}, {29'b0, S_ISSUE});
    chk("rd_req_cycle1", {31'b0, mem_req}, 32'd0);
    chk("rd_addr", mem_addr, 32'h0000_1238);
    chk("rd_busy", {31'b0, busy}, 32'd1);
    step();
    chk("rd_req_cycle2", {31'b0, mem_req}, 32'd1);
    chk("rd_rw", {31'b0, mem_rw}, 32'd1);
    step();
    chk("rd_req_hold", {31'b0, mem_req}, 32'd1);
    serve_read(0, 16'h00A0);
    chk("rd_busy_release", {31'b0, busy}, 32'd1);
    c0_req = 1'b0;
    step();
    chk("rd_busy_drop", {31'b0, busy}, 32'd0);

    // single write by c1
    c1_req = 1'b1; c1_rw = 1'b0; c1_addr = 32'h40; c1_wdata = 16'hBEEF;
    step();
    chk("wr_wdata", {16'b0, mem_wdata}, 32'h0000_BEEF);
    chk("wr_rw", {31'b0, mem_rw}, 32'd0);
    chk("wr_addr", mem_addr, 32'h40);
    step();
    chk("wr_state", {29'b0, state_dbg}, {29'b0, S_WRWAIT});
    chk("wr_req", {31'b0, mem_req}, 32'd1);
    chk("wr_ack_early", {31'b0, c1_wr_ack}, 32'd0);
    mem_wr_ack = 1'b1; #1;
    chk("wr_ack_c1", {31'b0, c1_wr_ack}, 32'd1);
    chk("wr_ack_c0", {31'b0, c0_wr_ack}, 32'd0);
    step();
    mem_wr_ack = 1'b0; #1;
    chk("wr_req_after", {31'b0, mem_req}, 32'd0);
    chk("wr_ack_once", {31'b0, c1_wr_ack}, 32'd0);
    chk("wr_release", {29'b0, state_dbg}, {29'b0, S_RELEASE});
    c1_req = 1'b0;
    step();
    chk("wr_idle", {29'b0, state_dbg}, {29'b0, S_IDLE});

    // tie after reset, both held
    do_reset();
    c0_req = 1'b1; c0_rw = 1'b1; c0_addr = 32'h100;
    c1_req = 1'b1; c1_rw = 1'b1; c1_addr = 32'h200;
    step();
    for (int i = 0; i < 3; i++) begin
      own = int'(tie_exp[i]);
      chk("tie_grant", mem_addr, (own == 1) ? 32'h200 : 32'h100);
      serve_read(own, 16'h0010 * 16'(i + 1));
      if (own == 1) c1_req = 1'b0; else c0_req = 1'b0;
      if (i == 2) begin
        c0_req = 1'b0; c1_req = 1'b0;
      end
      step();
      chk("tie_idle", {29'b0, state_dbg}, {29'b0, S_IDLE});
      if (i < 2) begin
        if (own == 1) c1_req = 1'b1; else c0_req = 1'b1;
        step();
      end
    end

    // held request through RELEASE
    do_reset();
    c0_req = 1'b1; c0_rw = 1'b1; c0_addr = 32'h300;
    step(); step();
    c1_req = 1'b1; c1_rw = 1'b1; c1_addr = 32'h400;
    serve_read(0, 16'h00C0);
    for (int i = 0; i < 3; i++) begin
      chk("held_release", {29'b0, state_dbg}, {29'b0, S_RELEASE});
      chk("held_no_req", {31'b0, mem_req}, 32'd0);
      step();
    end
    c0_req = 1'b0;
    step();
    chk("held_idle", {29'b0, state_dbg}, {29'b0, S_IDLE});
    c0_req = 1'b1;
    step();
`ifdef CACHE_ARB_FIXED_PRI_EN
    own = 0;
`else
    own = 1;
`endif
    chk("held_next_grant", mem_addr, (own == 1) ? 32'h400 : 32'h300);
    serve_read(own, 16'h00D0);
    c0_req = 1'b0; c1_req = 1'b0;
    step();
    chk("held_done", {29'b0, state_dbg}, {29'b0, S_IDLE});

    // reset mid-burst on fill word 2
    do_reset();
    c0_req = 1'b1; c0_rw = 1'b1; c0_addr = 32'h500;
    step(); step();
    mem_fill = 1'b1; mem_rdata = 16'h00E0; #1;
    chk("mid_fill_w1", {31'b0, c0_fill}, 32'd1);
    step();
    mem_fill = 1'b0; mem_rdata = 16'h00E1;
    reset = 1'b0; c0_req = 1'b0;
    step();
    chk("mid_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
    chk("mid_req", {31'b0, mem_req}, 32'd0);
    chk("mid_busy", {31'b0, busy}, 32'd0);
    mem_fill = 1'b1; #1;
    chk("mid_no_fill_c0", {31'b0, c0_fill}, 32'd0);
    chk("mid_no_fill_c1", {31'b0, c1_fill}, 32'd0);
    mem_fill = 1'b0; reset = 1'b1;
    step();
    chk("mid_idle_after", {29'b0, state_dbg}, {29'b0, S_IDLE});

    // spurious events while IDLE
    mem_fill = 1'b1; #1;
    chk("spur_fill_c0", {31'b0, c0_fill}, 32'd0);
    chk("spur_fill_c1", {31'b0, c1_fill}, 32'd0);
    step();
    mem_fill = 1'b0;
    chk("spur_fill_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
    mem_wr_ack = 1'b1; #1;
    chk("spur_ack_c0", {31'b0, c0_wr_ack}, 32'd0);
    chk("spur_ack_c1", {31'b0, c1_wr_ack}, 32'd0);
    step();
    mem_wr_ack = 1'b0;
    chk("spur_ack_state", {29'b0, state_dbg}, {29'b0, S_IDLE});
    chk("spur_busy", {31'b0, busy}, 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
